uart_result_tx: RTL and testbench
=================================

UART_RESULT_TX -- requirements
Module: uart_result_tx

Interface
REQ-001 SHALL have parameter CLK_FRQ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 SHALL have localparam CLKS_PER_BIT = (CLK_FRQ + BAUD/2) / BAUD, meaning clocks per bit time; elaboration SHALL fail if it is < 2.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 res_valid  input  1  digest/nonce pair offered.
REQ-008 res_ready  output  1  block idle and able to accept a pair.
REQ-009 res_digest  input  256  SHA-256 result; bits [255:248] are sent first.
REQ-010 res_nonce  input  32  winning nonce; bits [31:24] are sent first.
REQ-011 TxD  output  1  serial line; idles high.
REQ-012 busy  output  1  frame in progress.
REQ-013 frame_done  output  1  one-cycle pulse when a frame completes.

Function
REQ-014 A transfer SHALL occur on a rising clk edge where res_valid & res_ready are both high.
- On transfer: latch res_digest and res_nonce.
- res_ready SHALL fall and busy SHALL rise in the next cycle.
REQ-015 While busy, changes on res_valid, res_digest and res_nonce SHALL be ignored.
REQ-016 Each frame SHALL be 38 bytes, in this order:
- byte 0: 0xA5 (sync).
- bytes 1-32: digest, MSB byte first.
- bytes 33-36: nonce, MSB byte first.
- byte 37: XOR of bytes 1-36; the sync byte is excluded.
REQ-017 The checksum SHALL accumulate as payload bytes are loaded, or be computed from the latched data; either way, byte 37 SHALL equal the XOR of bytes 1-36.
REQ-018 Each byte SHALL be serialized as:
- start bit 0;
- 8 data bits, LSB first;
- two stop bits of 1;
- total 11 bit times.
REQ-019 Every bit time SHALL last exactly CLKS_PER_BIT clocks, timed by a down-counter reloaded at each bit boundary, with no cumulative drift.
REQ-020 The bit state machine SHALL have states IDLE, START, DATA, STOP1, STOP2.
- IDLE->START on transfer.
- START->DATA after 1 bit time.
- DATA->STOP1 after 8 bit times; a 3-bit index counts 0..7.
- STOP1->STOP2 after 1 bit time.
- STOP2->START if byte index < 37, else STOP2->IDLE.
REQ-021 The start bit of byte 0 SHALL appear on TxD in the cycle after the transfer.
- Consecutive bytes SHALL be back-to-back, with no idle gap beyond the two stop bits.
REQ-022 The byte index (6 bits, 0..37) SHALL increment at each STOP2 exit and SHALL clear in IDLE.
REQ-023 On STOP2 exit of byte 37:
- frame_done SHALL be high for exactly one cycle;
- in that same cycle, res_ready SHALL be high and busy low.
REQ-024 A transfer in the frame_done cycle SHALL be accepted and SHALL start a new frame on the next cycle; consecutive frames are separated only by the stop bits.
REQ-025 TxD SHALL be registered and glitch-free; it SHALL be 1 in IDLE, STOP1 and STOP2.
REQ-026 Total frame duration SHALL be 38*11*CLKS_PER_BIT clocks, measured from the first start-bit cycle to frame_done.

Reset
REQ-027 While rst is high, regardless of clk, outputs SHALL be:
- TxD = 1
- res_ready = 1
- busy = 0
- frame_done = 0
- state = IDLE, all counters zero.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately.
- TxD returns high asynchronously.
- No frame_done is produced.
- After rst falls, the block waits in IDLE for a new transfer.
REQ-029 A res_valid that is high during reset SHALL NOT be accepted until the first rising clk edge with rst low.

Verification
All scenarios use CLK_FRQ = 1_152_000 and BAUD = 115200, so CLKS_PER_BIT = 10.
REQ-030 Basic frame:
- Stimulus: digest = 0, nonce = 0x01020304, single transfer.
- Required: decoded bytes A5, 32×00, 01 02 03 04, checksum 04.
- Required: frame_done exactly 4180 clocks after the first start bit.
REQ-031 Bit timing:
- Stimulus: any frame.
- Required: each bit is stable for exactly 10 clocks; byte 0 reads 0,1,0,1,0,0,1,0,1,1,1 (0xA5 LSB first with framing).
- Required: no gap between bytes.
REQ-032 Handshake:
- Stimulus: hold res_valid high continuously; change res_digest mid-frame.
- Required: the first frame carries the originally latched digest.
- Required: the second frame starts the cycle after frame_done, and res_ready is high only in the frame_done cycle.
REQ-033 Checksum:
- Stimulus: digest = 0xFF repeated in every byte, nonce = 0xDEADBEEF.
- Required: checksum byte = 0xDE^0xAD^0xBE^0xEF = 0x22 (the 32 0xFF bytes cancel).
REQ-034 Mid-frame reset:
- Stimulus: assert rst during byte 10.
- Required: TxD = 1 immediately, no frame_done, res_ready = 1.
- Required: a new transfer afterwards produces a complete correct frame.
REQ-035 Idle:
- Stimulus: res_valid low for 1000 cycles after reset.
- Required: TxD = 1, busy = 0, frame_done never pulses.

Source files
------------

// File: rtl/uart_result_tx.sv
// uart_result_tx: serialises a 38-byte result frame (sync, digest, nonce,
// XOR checksum) onto a UART line, 8 data bits LSB first, two stop bits.
module uart_result_tx #(
    parameter int CLK_FRQ = 50_000_000,
    parameter int BAUD    = 115200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         res_valid,
    output logic         res_ready,
    input  logic [255:0] res_digest,
    input  logic [31:0]  res_nonce,
    output logic         TxD,
    output logic         busy,
    output logic         frame_done
);

    localparam int CLKS_PER_BIT = (CLK_FRQ + BAUD / 2) / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [5:0] LAST_BYTE = 6'd37;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // A bit time shorter than two clocks cannot be timed by the down-counter.
    generate
        if (CLKS_PER_BIT < 2) begin : gBadBaud
            $error("uart_result_tx: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, STOP1, STOP2} state_t;

    state_t             stateReg, stateNext;
    logic [CNT_W-1:0]   cntReg, cntNext;
    logic [2:0]         bitIdxReg, bitIdxNext;
    logic [5:0]         byteIdxReg, byteIdxNext;
    logic [287:0]       payloadReg, payloadNext;   // {digest, nonce}, shifted out MSB byte first
    logic [7:0]         csumReg, csumNext;
    logic [6:0]         shiftReg, shiftNext;       // remaining data bits of the current byte
    logic               txdReg, txdNext;
    logic               doneReg, doneNext;

    logic               bitEnd;
    logic [7:0]         curByte;

    assign bitEnd    = (cntReg == '0);
    assign res_ready = (stateReg == IDLE);
    assign busy      = (stateReg != IDLE);
    assign TxD       = txdReg;
    assign frame_done = doneReg;

    // Byte to send for the current index: sync, payload head, or checksum.
    always_comb begin
        if (byteIdxReg == 6'd0)
            curByte = SYNC_BYTE;
        else if (byteIdxReg == LAST_BYTE)
            curByte = csumReg;
        else
            curByte = payloadReg[287:280];
    end

    // Next-state and datapath decisions; TxD is registered from txdNext.
    always_comb begin
        stateNext   = stateReg;
        cntNext     = cntReg;
        bitIdxNext  = bitIdxReg;
        byteIdxNext = byteIdxReg;
        payloadNext = payloadReg;
        csumNext    = csumReg;
        shiftNext   = shiftReg;
        txdNext     = txdReg;
        doneNext    = 1'b0;

        if (stateReg != IDLE)
            cntNext = bitEnd ? CNT_RELOAD : cntReg - 1'b1;

        case (stateReg)
            IDLE: begin
                byteIdxNext = 6'd0;
                bitIdxNext  = 3'd0;
                txdNext     = 1'b1;
                if (res_valid) begin
                    payloadNext = {res_digest, res_nonce};
                    csumNext    = 8'h00;
                    cntNext     = CNT_RELOAD;
                    txdNext     = 1'b0;
                    stateNext   = START;
                end
            end
            START: begin
                if (bitEnd) begin
                    // Load the byte at the end of its start bit; payload bytes
                    // are folded into the checksum as they are consumed.
                    txdNext    = curByte[0];
                    shiftNext  = curByte[7:1];
                    bitIdxNext = 3'd0;
                    stateNext  = DATA;
                    if (byteIdxReg != 6'd0 && byteIdxReg != LAST_BYTE) begin
                        payloadNext = payloadReg << 8;
                        csumNext    = csumReg ^ curByte;
                    end
                end
            end
            DATA: begin
                if (bitEnd) begin
                    if (bitIdxReg == 3'd7) begin
                        txdNext   = 1'b1;
                        stateNext = STOP1;
                    end else begin
                        txdNext    = shiftReg[0];
                        shiftNext  = {1'b0, shiftReg[6:1]};
                        bitIdxNext = bitIdxReg + 3'd1;
                    end
                end
            end
            STOP1: begin
                if (bitEnd)
                    stateNext = STOP2;
            end
            STOP2: begin
                if (bitEnd) begin
                    if (byteIdxReg < LAST_BYTE) begin
                        byteIdxNext = byteIdxReg + 6'd1;
                        txdNext     = 1'b0;
                        stateNext   = START;
                    end else begin
                        byteIdxNext = 6'd0;
                        txdNext     = 1'b1;
                        doneNext    = 1'b1;
                        stateNext   = IDLE;
                    end
                end
            end
            default: begin
                txdNext   = 1'b1;
                stateNext = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg   <= IDLE;
            cntReg     <= '0;
            bitIdxReg  <= 3'd0;
            byteIdxReg <= 6'd0;
            payloadReg <= '0;
            csumReg    <= 8'h00;
            shiftReg   <= 7'd0;
            txdReg     <= 1'b1;
            doneReg    <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            cntReg     <= cntNext;
            bitIdxReg  <= bitIdxNext;
            byteIdxReg <= byteIdxNext;
            payloadReg <= payloadNext;
            csumReg    <= csumNext;
            shiftReg   <= shiftNext;
            txdReg     <= txdNext;
            doneReg    <= doneNext;
        end
    end

endmodule

// File: tb/tb_uart_result_tx.sv
// Testbench for uart_result_tx: directed and random frames decoded from TxD
// and compared with a byte-level reference model.
module tb_uart_result_tx;

    localparam int CLK_FRQ = 1_152_000;
    localparam int BAUD    = 115200;
    localparam int CPB     = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         res_valid;
    logic         res_ready;
    logic [255:0] res_digest;
    logic [31:0]  res_nonce;
    logic         TxD;
    logic         busy;
    logic         frame_done;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] expBytes [38];
    logic [7:0] gotBytes [38];

    uart_result_tx #(.CLK_FRQ(CLK_FRQ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .rst        (rst),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_digest (res_digest),
        .res_nonce  (res_nonce),
        .TxD        (TxD),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference frame: sync, digest bytes MSB first, nonce bytes MSB first, XOR.
    function automatic void buildExp(input logic [255:0] d, input logic [31:0] n);
        logic [7:0] x;
        expBytes[0] = 8'hA5;
        for (int i = 0; i < 32; i++) expBytes[1 + i] = d[255 - 8*i -: 8];
        for (int i = 0; i < 4; i++)  expBytes[33 + i] = n[31 - 8*i -: 8];
        x = 8'h00;
        for (int i = 1; i <= 36; i++) x = x ^ expBytes[i];
        expBytes[37] = x;
    endfunction

    function automatic logic [255:0] randDigest();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer a pair at a negedge; it is taken at the following posedge.
    task automatic offer(input logic [255:0] d, input logic [31:0] n, input bit hold);
        @(negedge clk);
        res_digest = d;
        res_nonce  = n;
        res_valid  = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) res_valid = 1'b0;
    endtask

    // Decode a whole frame starting the cycle after the transfer edge, checking
    // every bit time is 10 stable clocks with correct framing and value.
    task automatic recvFrame(input string tag, input int changeBit,
                             input logic [255:0] newDigest, input bit keepGoing);
        int sideBad;
        int unstable;
        logic first, s, expBit;
        logic [7:0] dec;
        sideBad = 0;
        for (int k = 0; k < 38; k++) begin
            dec = 8'h00;
            for (int b = 0; b < 11; b++) begin
                if (b == 0)      expBit = 1'b0;
                else if (b <= 8) expBit = expBytes[k][b-1];
                else             expBit = 1'b1;
                unstable = 0;
                first = 1'b0;
                for (int c = 0; c < CPB; c++) begin
                    @(negedge clk);
                    if (k*11 + b == changeBit && c == 0) res_digest = newDigest;
                    s = TxD;
                    if (c == 0) first = s;
                    else if (s !== first) unstable++;
                    if (busy !== 1'b1 || res_ready !== 1'b0 || frame_done !== 1'b0) sideBad++;
                end
                compared++;
                assert (unstable == 0 && first === expBit) else begin
                    mismatched++;
                    $error("FAIL %s bit byte%0d/bit%0d: observed %b (unstable %0d) expected %b",
                           tag, k, b, first, unstable, expBit);
                end
                if (b >= 1 && b <= 8) dec[b-1] = first;
            end
            gotBytes[k] = dec;
            check($sformatf("%s byte%0d", tag, k), {24'd0, dec}, {24'd0, expBytes[k]});
        end
        check({tag, " in-frame flags"}, sideBad, 0);
        @(negedge clk);
        check({tag, " done cycle ready/busy/done"}, {29'd0, res_ready, busy, frame_done}, 32'b101);
        if (!keepGoing) begin
            @(negedge clk);
            check({tag, " done one cycle"}, {31'd0, frame_done}, 32'd0);
        end
        $display("frame %s: %0d bytes decoded, checksum %02h", tag, 38, gotBytes[37]);
    endtask

    initial begin
        logic [255:0] d, d2;
        logic [31:0]  n;
        int bad;

        rst = 1'b1;
        res_valid = 1'b0;
        res_digest = '0;
        res_nonce = '0;
        #1;
        check("reset outputs async", {28'd0, TxD, res_ready, busy, frame_done}, 32'b1100);
        repeat (3) @(negedge clk);
        check("reset outputs clocked", {28'd0, TxD, res_ready, busy, frame_done}, 32'b1100);
        rst = 1'b0;

        // Idle: nothing offered for 1000 cycles.
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || res_ready !== 1'b1) bad++;
        end
        check("idle 1000 cycles", bad, 0);
        $display("idle: 1000 cycles observed");

        // Basic frame.
        d = '0; n = 32'h01020304;
        buildExp(d, n);
        offer(d, n, 1'b0);
        recvFrame("basic", -1, '0, 1'b0);
        check("basic checksum", {24'd0, gotBytes[37]}, 32'h04);

        // Checksum frame: FF digest cancels out.
        d = {32{8'hFF}}; n = 32'hDEADBEEF;
        buildExp(d, n);
        offer(d, n, 1'b0);
        recvFrame("cksum", -1, '0, 1'b0);
        check("cksum checksum", {24'd0, gotBytes[37]}, 32'h22);

        // Random frames.
        for (int r = 0; r < 2; r++) begin
            d = randDigest(); n = $urandom;
            buildExp(d, n);
            offer(d, n, 1'b0);
            recvFrame($sformatf("rand%0d", r), -1, '0, 1'b0);
        end

        // Handshake: valid held high, digest changed mid-frame.
        d = randDigest(); d2 = randDigest(); n = $urandom;
        buildExp(d, n);
        offer(d, n, 1'b1);
        recvFrame("hold1", 150, d2, 1'b1);
        buildExp(d2, n);
        recvFrame("hold2", -1, '0, 1'b1);
        res_valid = 1'b0;
        @(negedge clk);
        check("after hold ready/busy/done", {29'd0, res_ready, busy, frame_done}, 32'b100);

        // Mid-frame reset during byte 10's start bit.
        d = randDigest(); n = $urandom;
        buildExp(d, n);
        offer(d, n, 1'b0);
        repeat (10*11*CPB + 5) @(negedge clk);
        check("byte10 start bit low", {31'd0, TxD}, 32'd0);
        #2;
        rst = 1'b1;
        res_valid = 1'b1;
        d = randDigest(); n = $urandom;
        res_digest = d;
        res_nonce = n;
        #1;
        check("midreset async outputs", {28'd0, TxD, res_ready, busy, frame_done}, 32'b1100);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1 || res_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        check("valid ignored during reset", bad, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        buildExp(d, n);
        recvFrame("postreset", -1, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
